// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - machine trap CSR addresses, op encoding and write masks
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_NONE  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_t;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/csr_op_alu.sv
// rtl/csr_op_alu.sv - combinational CSR read-modify-write value (write/set/clear)
module csr_op_alu
    import csr_pkg::*;
(
    input  logic [31:0] old_val,
    input  logic [31:0] din,
    input  logic [1:0]  op,
    output logic [31:0] new_val
);

    csr_op_t op_e;
    assign op_e = csr_op_t'(op);

    always_comb begin
        new_val = old_val;
        case (op_e)
            CSR_WRITE: new_val = din;
            CSR_SET:   new_val = old_val | din;
            CSR_CLEAR: new_val = old_val & ~din;
            default:   new_val = old_val;
        endcase
    end

endmodule

// File: rtl/mtrap_csr.sv
// rtl/mtrap_csr.sv - machine trap-setup/handling CSR file; MCOUNTERS_EN adds mcycle/minstret
module mtrap_csr
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC    = 32'h0000_0000,
    parameter int          HART_IRQ_LINES = 3
) (
    input  logic        clk,
    input  logic        rst,
`ifdef MCOUNTERS_EN
    input  logic        instret,
`endif
    input  logic [11:0] addr,
    input  logic [31:0] din,
    input  logic [1:0]  op,
    input  logic        wr_en,
    output logic [31:0] dout,
    output logic        illegal_address,
    input  logic        trap,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret,
    input  logic        sw_irq,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic        irq_pending,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out
);

    logic                      mstatus_mie_q, mstatus_mie_d;
    logic                      mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0]               mie_q, mie_d;
    logic [31:0]               mtvec_q, mtvec_d;
    logic [31:0]               mscratch_q, mscratch_d;
    logic [31:0]               mepc_q, mepc_d;
    logic [31:0]               mcause_q, mcause_d;
    logic [31:0]               mtval_q, mtval_d;
    logic [HART_IRQ_LINES-1:0] mip_q, mip_d;
`ifdef MCOUNTERS_EN
    logic [63:0]               mcycle_q, mcycle_d;
    logic [63:0]               minstret_q, minstret_d;
`endif

    logic [31:0] mstatus_rd, mip_rd, rdata, alu_new;
    logic        known, write_req, commit;

    assign mstatus_rd = MSTATUS_FIXED | {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    assign mip_rd     = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};

    always_comb begin
        rdata = 32'b0;
        known = 1'b1;
        case (addr)
            CSR_MSTATUS:   rdata = mstatus_rd;
            CSR_MIE:       rdata = mie_q;
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP:       rdata = mip_rd;
`ifdef MCOUNTERS_EN
            CSR_MCYCLE:    rdata = mcycle_q[31:0];
            CSR_MCYCLEH:   rdata = mcycle_q[63:32];
            CSR_MINSTRET:  rdata = minstret_q[31:0];
            CSR_MINSTRETH: rdata = minstret_q[63:32];
`endif
            default:       known = 1'b0;
        endcase
    end

    assign write_req       = wr_en && (op != CSR_NONE);
    assign illegal_address = !known || ((addr == CSR_MIP) && write_req);
    assign commit          = write_req && !illegal_address;
    assign dout            = rdata;

    // The addressed register's current value is the ALU's old operand, counters included.
    csr_op_alu u_alu (
        .old_val (rdata),
        .din     (din),
        .op      (op),
        .new_val (alu_new)
    );

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mip_d          = {ext_irq, timer_irq, sw_irq};

        if (commit) begin
            case (addr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = alu_new[MSTATUS_MIE];
                    mstatus_mpie_d = alu_new[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_d      = alu_new & MIE_WMASK;
                CSR_MTVEC:    mtvec_d    = alu_new[1] ? {alu_new[31:2], 2'b00} : alu_new;
                CSR_MSCRATCH: mscratch_d = alu_new;
                CSR_MEPC:     mepc_d     = alu_new & MEPC_WMASK;
                CSR_MCAUSE:   mcause_d   = alu_new;
                CSR_MTVAL:    mtval_d    = alu_new;
                default: ;
            endcase
        end

        // Layered so mret beats a CSR write and trap beats both.
        if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
        if (trap) begin
            mepc_d         = trap_pc & MEPC_WMASK;
            mcause_d       = trap_cause;
            mtval_d        = trap_val;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'b0;
            mtvec_q        <= RESET_MTVEC;
            mscratch_q     <= 32'b0;
            mepc_q         <= 32'b0;
            mcause_q       <= 32'b0;
            mtval_q        <= 32'b0;
            mip_q          <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mip_q          <= mip_d;
        end
    end

`ifdef MCOUNTERS_EN
    // A written half takes the ALU value; the other half keeps its normal increment.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'b0, instret};
        if (commit) begin
            case (addr)
                CSR_MCYCLE:    mcycle_d[31:0]    = alu_new;
                CSR_MCYCLEH:   mcycle_d[63:32]   = alu_new;
                CSR_MINSTRET:  minstret_d[31:0]  = alu_new;
                CSR_MINSTRETH: minstret_d[63:32] = alu_new;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q   <= 64'b0;
            minstret_q <= 64'b0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif

    logic [31:0] tvec_base;
    assign tvec_base = {mtvec_q[31:2], 2'b00};

    always_comb begin
        trap_vector = tvec_base;
        if ((mtvec_q[1:0] == 2'b01) && trap_cause[31])
            trap_vector = tvec_base + {trap_cause[29:0], 2'b00};
    end

    assign irq_pending = mstatus_mie_q & |(mip_rd & mie_q);
    assign mepc_out    = mepc_q;

endmodule

// File: tb/tb_mtrap_csr.sv
// tb/tb_mtrap_csr.sv - randomized self-checking bench for mtrap_csr against a behavioural model
module tb_mtrap_csr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] addr = 12'h0;
    logic [31:0] din = 32'h0;
    logic [1:0]  op = 2'b00;
    logic        wr_en = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] trap_cause = 32'h0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] trap_val = 32'h0;
    logic        mret = 1'b0;
    logic        sw_irq = 1'b0, timer_irq = 1'b0, ext_irq = 1'b0;
    logic        instret = 1'b0;
    logic [31:0] dout, trap_vector, mepc_out;
    logic        illegal_address, irq_pending;

    int n_tests = 0;
    int n_fail  = 0;

    mtrap_csr #(.RESET_MTVEC(32'h8000_0000), .HART_IRQ_LINES(3)) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef MCOUNTERS_EN
        .instret         (instret),
`endif
        .addr            (addr),
        .din             (din),
        .op              (op),
        .wr_en           (wr_en),
        .dout            (dout),
        .illegal_address (illegal_address),
        .trap            (trap),
        .trap_cause      (trap_cause),
        .trap_pc         (trap_pc),
        .trap_val        (trap_val),
        .mret            (mret),
        .sw_irq          (sw_irq),
        .timer_irq       (timer_irq),
        .ext_irq         (ext_irq),
        .irq_pending     (irq_pending),
        .trap_vector     (trap_vector),
        .mepc_out        (mepc_out)
    );

    always #5 clk = ~clk;

    // Architectural state of the model, held as whole register images.
    bit [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_mip;
    bit [63:0] m_cyc, m_ins;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 32'h8000_0000; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0; m_cyc = 0; m_ins = 0;
    endfunction

    function automatic void mread(input bit [11:0] a, output bit [31:0] v, output bit ok);
        ok = 1'b1;
        v  = 32'h0;
        case (a)
            12'h300: v = m_mstatus;
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = m_mip;
`ifdef MCOUNTERS_EN
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[31:0];
            12'hB82: v = m_ins[63:32];
`endif
            default: ok = 1'b0;
        endcase
    endfunction

    function automatic void model_step();
        bit [31:0] old, nv, ms;
        bit        ok, we, commit, old_mie, old_mpie;
        mread(addr, old, ok);
        we      = wr_en && (op != 2'b00);
        commit  = we && ok && (addr != 12'h344);
        old_mie = m_mstatus[3];
        old_mpie = m_mstatus[7];
        case (op)
            2'b01:   nv = din;
            2'b10:   nv = old | din;
            default: nv = old & ~din;
        endcase
        m_cyc = m_cyc + 1;
        m_ins = m_ins + 64'(instret);
        ms = m_mstatus;
        if (commit) begin
            case (addr)
                12'h300: ms = 32'h1800 | (nv & 32'h88);
                12'h304: m_mie = nv & 32'h888;
                12'h305: m_mtvec = (nv[1:0] >= 2) ? (nv & ~32'd3) : nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'd3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: m_cyc[31:0] = nv;
                12'hB80: m_cyc[63:32] = nv;
                12'hB02: m_ins[31:0] = nv;
                12'hB82: m_ins[63:32] = nv;
                default: ;
            endcase
        end
        if (trap) begin
            ms = 32'h1800 | (old_mie ? 32'h80 : 32'h0);
            m_mepc = trap_pc & ~32'd3;
            m_mcause = trap_cause;
            m_mtval = trap_val;
        end else if (mret) begin
            ms = 32'h1880 | (old_mpie ? 32'h8 : 32'h0);
        end
        m_mstatus = ms;
        m_mip = (ext_irq ? 32'h800 : 0) | (timer_irq ? 32'h80 : 0) | (sw_irq ? 32'h8 : 0);
    endfunction

    function automatic bit [31:0] exp_vector();
        bit [31:0] base, off;
        base = m_mtvec & ~32'd3;
        off  = {1'b0, trap_cause[30:0]};
        if (m_mtvec[1:0] == 2'd1 && trap_cause[31]) return base + off * 4;
        return base;
    endfunction

    task automatic drv(input bit [11:0] a, input bit [31:0] d, input bit [1:0] o, input bit we,
                       input bit tr, input bit [31:0] tc, input bit mr);
        addr = a; din = d; op = o; wr_en = we; trap = tr; trap_cause = tc; mret = mr;
        trap_pc = $urandom; trap_val = $urandom;
    endtask

    task automatic tick();
        bit [31:0] ev;
        bit        ok;
        #1;
        mread(addr, ev, ok);
        chk("dout", dout, ev);
        chk("illegal_address", illegal_address,
            !ok || (addr == 12'h344 && wr_en && op != 2'b00));
        chk("irq_pending", irq_pending, m_mstatus[3] && ((m_mip & m_mie) != 0));
        chk("trap_vector", trap_vector, exp_vector());
        chk("mepc_out", mepc_out, m_mepc);
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd_const(input string tag, input bit [11:0] a, input bit [31:0] exp);
        drv(a, 0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk(tag, dout, exp);
        tick();
    endtask

    bit [11:0] addr_tab [16] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                 12'hF11, 12'h345, 12'h300, 12'h305};
    bit [11:0] rst_addr [3] = '{12'h300, 12'h305, 12'h341};
    bit [31:0] rst_val  [3] = '{32'h1800, 32'h8000_0000, 32'h0};

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            addr = rst_addr[i];
            #1;
            chk("reset_read", dout, rst_val[i]);
        end
        chk("reset_irq_pending", irq_pending, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // mscratch write / set / clear
        drv(12'h340, 32'hA5A5_0000, 2'b01, 1'b1, 0, 0, 0); tick();
        drv(12'h340, 32'h0000_00FF, 2'b10, 1'b1, 0, 0, 0); tick();
        rd_const("mscratch_set", 12'h340, 32'hA5A5_00FF);
        drv(12'h340, 32'hA500_0000, 2'b11, 1'b1, 0, 0, 0); tick();
        rd_const("mscratch_clear", 12'h340, 32'h00A5_00FF);

        // timer interrupt then trap entry
        drv(12'h300, 32'h8, 2'b10, 1'b1, 0, 0, 0); tick();
        timer_irq = 1'b1;
        drv(12'h304, 32'h80, 2'b01, 1'b1, 0, 0, 0); tick();
        rd_const("mip_timer", 12'h344, 32'h80);
        chk("irq_pending_timer", irq_pending, 1'b1);
        drv(12'h300, 0, 2'b00, 1'b0, 1'b1, 32'h8000_0007, 1'b0);
        trap_pc = 32'h1006;
        tick();
        timer_irq = 1'b0;
        rd_const("mepc_trap", 12'h341, 32'h1004);
        rd_const("mstatus_trap", 12'h300, 32'h1880);
        chk("irq_pending_after_trap", irq_pending, 1'b0);

        // mtvec mode handling and vectored target
        drv(12'h305, 32'h2000_0003, 2'b01, 1'b1, 0, 0, 0); tick();
        rd_const("mtvec_mode3", 12'h305, 32'h2000_0000);
        drv(12'h305, 32'h2000_0001, 2'b01, 1'b1, 0, 0, 0); tick();
        drv(12'h305, 0, 2'b00, 1'b0, 1'b0, 32'h8000_000B, 1'b0); #1;
        chk("vector_irq", trap_vector, 32'h2000_002C);
        tick();
        drv(12'h305, 0, 2'b00, 1'b0, 1'b0, 32'h2, 1'b0); #1;
        chk("vector_exc", trap_vector, 32'h2000_0000);
        tick();

        // trap + mret + mstatus write together, then mret alone
        drv(12'h300, 32'h8, 2'b01, 1'b1, 0, 0, 0); tick();
        drv(12'h300, 32'h8, 2'b01, 1'b1, 1'b1, 32'h3, 1'b1); tick();
        rd_const("mstatus_trap_mret", 12'h300, 32'h1880);
        drv(12'h300, 0, 2'b00, 1'b0, 1'b0, 0, 1'b1); tick();
        rd_const("mstatus_mret", 12'h300, 32'h1888);

        // illegal addresses and read-only mip
        drv(12'hF11, 0, 2'b00, 1'b0, 0, 0, 0); #1;
        chk("illegal_f11", {illegal_address, dout}, {1'b1, 32'h0});
        tick();
        drv(12'h345, 0, 2'b00, 1'b0, 0, 0, 0); #1;
        chk("illegal_345", {illegal_address, dout}, {1'b1, 32'h0});
        tick();
        drv(12'h344, 32'hFFFF_FFFF, 2'b01, 1'b1, 0, 0, 0); #1;
        chk("illegal_mip_write", illegal_address, 1'b1);
        tick();
        rd_const("mip_unchanged", 12'h344, 32'h0);

`ifdef MCOUNTERS_EN
        drv(12'hB00, 32'hFFFF_FFFF, 2'b01, 1'b1, 0, 0, 0); tick();
        tick();
        rd_const("mcycleh_carry", 12'hB80, 32'h1);
`endif

        // randomized phase, with two asynchronous resets mid-operation
        for (int i = 0; i < 400; i++) begin
            bit [31:0] ev;
            bit        ok;
            drv(addr_tab[$urandom_range(0, 15)], $urandom, 2'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) {ext_irq, timer_irq, sw_irq} = 3'($urandom);
            instret = 1'($urandom);
            if (i == 150 || i == 300) begin
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                mread(addr, ev, ok);
                chk("async_reset_dout", dout, ev);
                chk("async_reset_irq", irq_pending, 1'b0);
                chk("async_reset_mepc", mepc_out, 32'h0);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
